// File: rtl/matrix_stream_bridge.sv
// Stream front/back end for the 4x4 matrix ALU: op word + A + B in, 16-element result out.
// Optional macro MSB_UNARY_SKIP_EN lets unary opcodes skip the B load.
module matrix_stream_bridge #(
    parameter int unsigned ELEM_W = 16,
    parameter int unsigned DIM    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [ELEM_W-1:0]         s_data,
    output logic [ELEM_W*DIM*DIM-1:0] alu_matrix_a,
    output logic [ELEM_W*DIM*DIM-1:0] alu_matrix_b,
    output logic [3:0]                alu_op,
    input  logic [ELEM_W*DIM*DIM-1:0] alu_matrix_c,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [ELEM_W-1:0]         m_data,
    output logic                      m_last,
    output logic                      busy
);
    localparam int unsigned N  = DIM * DIM;
    localparam int unsigned MW = ELEM_W * N;
    localparam int unsigned CW = $clog2(N);
    localparam logic [CW-1:0] CntMax = CW'(N - 1);

    typedef enum logic [2:0] {StIdle, StLoadA, StLoadB, StExec, StDrain} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [MW-1:0] a_q, b_q, res_q;
    logic [3:0]    op_q;
    logic          cnt_last, s_fire, m_fire, skip_b;

`ifdef MSB_UNARY_SKIP_EN
    function automatic logic is_unary(input logic [3:0] op);
        return op inside {4'h0, 4'h5, 4'h9, 4'hA, 4'hB, 4'hC};
    endfunction
    assign skip_b = is_unary(op_q);
`else
    assign skip_b = 1'b0;
`endif

    assign cnt_last = (cnt_q == CntMax);
    assign s_fire   = s_valid && s_ready;
    assign m_fire   = m_valid && m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_ready = 1'b0;
        m_valid = 1'b0;
        busy    = 1'b1;
        unique case (state_q)
            StIdle: begin
                s_ready = 1'b1;
                busy    = 1'b0;
                if (s_valid) state_d = StLoadA;
            end
            StLoadA: begin
                s_ready = 1'b1;
                if (s_valid && cnt_last) state_d = skip_b ? StExec : StLoadB;
            end
            StLoadB: begin
                s_ready = 1'b1;
                if (s_valid && cnt_last) state_d = StExec;
            end
            StExec: begin
                state_d = StDrain;
            end
            StDrain: begin
                m_valid = 1'b1;
                if (m_ready && cnt_last) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            op_q  <= '0;
        end else begin
            if (s_fire) begin
                unique case (state_q)
                    StIdle: begin
                        op_q <= s_data[3:0];
`ifdef MSB_UNARY_SKIP_EN
                        // Unary ops never load B, so present a clean zero operand.
                        if (is_unary(s_data[3:0])) b_q <= '0;
`endif
                    end
                    StLoadA: begin
                        a_q[cnt_q*ELEM_W +: ELEM_W] <= s_data;
                        cnt_q <= cnt_q + 1'b1;
                    end
                    StLoadB: begin
                        b_q[cnt_q*ELEM_W +: ELEM_W] <= s_data;
                        cnt_q <= cnt_q + 1'b1;
                    end
                    default: ;
                endcase
            end
            if (state_q == StExec) res_q <= alu_matrix_c;
            if (m_fire) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign alu_matrix_a = a_q;
    assign alu_matrix_b = b_q;
    assign alu_op       = op_q;
    assign m_data       = (state_q == StDrain) ? res_q[cnt_q*ELEM_W +: ELEM_W] : '0;
    assign m_last       = (state_q == StDrain) && cnt_last;

endmodule
